parking_gate_arbiter: RTL

Controller that shares the single barrier gate of the lot between the entry lane and the exit lane. It sits beside the `parking_lot` occupancy counter. It takes lane requests from the card readers, the passage pulses (`dtc`) and the occupancy count (`cnt`) from the counter, and decides which lane the gate opens for. It refuses entry while the lot is full and times out a gate that nobody drives through.

---
 rtl/parking_gate_arbiter_if.sv | 21 ++
 rtl/parking_gate_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter_if.sv
// Lane request / gate status bundle shared between the lot-side logic and the gate arbiter.
interface parking_gate_arbiter_if;
   logic [1:0] req;        // [1] entry lane, [0] exit lane, level requests
   logic [1:0] dtc;        // [1] entry completed, [0] exit completed, one-cycle pulses
   logic [2:0] cnt;        // current lot occupancy
   logic [1:0] gnt;        // one-hot lane grant, held through the open phase
   logic       gate_open;  // barrier open command
   logic       full;       // registered cnt >= CAPACITY
   logic       deny;       // one pulse per refused entry episode
   logic       timeout;    // open phase ended without a passage

   modport master (
      output req, dtc, cnt,
      input  gnt, gate_open, full, deny, timeout
   );

   modport slave (
      input  req, dtc, cnt,
      output gnt, gate_open, full, deny, timeout
   );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shares the single barrier gate between the entry and exit lanes: round-robin
// grant, entry refusal while the lot is full, open-phase timeout and close delay.
module parking_gate_arbiter #(
   parameter int unsigned CAPACITY     = 7,
   parameter int unsigned OPEN_MAX     = 20,
   parameter int unsigned CLOSE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   parking_gate_arbiter_if.slave bus
);

   localparam int unsigned   TMAX       = (OPEN_MAX > CLOSE_CYCLES) ? OPEN_MAX : CLOSE_CYCLES;
   localparam int unsigned   TW         = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_MAX - 1);
   localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);
   localparam logic [2:0]    CAP        = 3'(CAPACITY);

   // Lane encoding for the round-robin pointer.
   localparam logic LANE_ENTRY = 1'b0;
   localparam logic LANE_EXIT  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      OPEN,
      CLOSE
   } state_t;

   state_t        state, state_next;
   logic          last, last_next;
   logic [TW-1:0] timer, timer_next;
   logic          deny_arm, deny_arm_next;
   logic [1:0]    gnt, gnt_next;
   logic          gate_open, gate_open_next;
   logic          full, full_next;
   logic          deny, deny_next;
   logic          timeout, timeout_next;

   logic          entry_ok;
   logic          exit_ok;
   logic          grant_exit;

   assign bus.gnt       = gnt;
   assign bus.gate_open = gate_open;
   assign bus.full      = full;
   assign bus.deny      = deny;
   assign bus.timeout   = timeout;

   // State and all registered outputs; reset drops the gate immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= LANE_EXIT;
         timer     <= '0;
         deny_arm  <= 1'b1;
         gnt       <= '0;
         gate_open <= 1'b0;
         full      <= 1'b0;
         deny      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_next;
         last      <= last_next;
         timer     <= timer_next;
         deny_arm  <= deny_arm_next;
         gnt       <= gnt_next;
         gate_open <= gate_open_next;
         full      <= full_next;
         deny      <= deny_next;
         timeout   <= timeout_next;
      end
   end

   // Next-state, grant selection, deny episode tracking and timers.
   always_comb begin
      state_next     = state;
      last_next      = last;
      timer_next     = timer;
      gnt_next       = gnt;
      gate_open_next = gate_open;
      deny_next      = 1'b0;
      timeout_next   = 1'b0;
      full_next      = (bus.cnt >= CAP);
      entry_ok       = bus.req[1] & ~full;
      exit_ok        = bus.req[0] & (bus.cnt != 3'd0);
      grant_exit     = (entry_ok & exit_ok) ? ~last : exit_ok;

      // Re-arm once the refused episode ends (request dropped or lot no longer full).
      deny_arm_next  = deny_arm | ~(bus.req[1] & full);

      case (state)
         IDLE: begin
            if (bus.req[1] & full & deny_arm) begin
               deny_next     = 1'b1;
               deny_arm_next = 1'b0;
            end
            if (entry_ok | exit_ok) begin
               state_next     = OPEN;
               last_next      = grant_exit;
               gnt_next       = grant_exit ? 2'b01 : 2'b10;
               gate_open_next = 1'b1;
               timer_next     = '0;
            end
         end

         OPEN: begin
            timer_next = timer + 1'b1;
            if ((gnt & bus.dtc) != 2'b00) begin
               state_next     = CLOSE;
               gnt_next       = '0;
               gate_open_next = 1'b0;
               timer_next     = '0;
            end else if (timer == OPEN_LAST) begin
               state_next     = CLOSE;
               gnt_next       = '0;
               gate_open_next = 1'b0;
               timer_next     = '0;
               timeout_next   = 1'b1;
            end
         end

         CLOSE: begin
            timer_next = timer + 1'b1;
            if (timer == CLOSE_LAST) begin
               state_next = IDLE;
               timer_next = '0;
            end
         end

         default: begin
            state_next     = IDLE;
            gnt_next       = '0;
            gate_open_next = 1'b0;
            timer_next     = '0;
         end
      endcase
   end

endmodule
